sreg_tx_ctrl: RTL

- Serialising controller built around an internal right-shift register.
- Accepts a parallel word through a valid/ready handshake, then shifts it out LSB-first on a single serial line at a programmable bit period.
- Pulses done when the word has been sent.
- Sits between a parallel producer and a serial link or peripheral pin.

---
 rtl/sreg_tx_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sreg_tx_ctrl.sv
// Parallel-in, serial-out transmitter: shifts an N-bit word out LSB-first, one bit per BIT_CYCLES clocks.
// Latency: handshake at edge k puts bit 0 on sout in cycle k+1; done pulses in cycle k+N*BIT_CYCLES+1 (+BIT_CYCLES with parity).
// Backpressure: start_ready is high only in IDLE; a producer holding start_valid is accepted on the first IDLE edge.
// Optional feature macro: SREG_TX_PARITY_EN appends an even-parity bit after the data bits.
module sreg_tx_ctrl #(
    parameter int N          = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [N-1:0] din,
    input  logic         abort,
    output logic         sout,
    output logic         busy,
    output logic         done
);

    localparam int              BW       = $clog2(N);
    localparam logic [BW-1:0]   BIT_LAST = BW'(N - 1);
    localparam logic [7:0]      PER_LAST = 8'(BIT_CYCLES - 1);

`ifdef SREG_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        PAR   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
`endif

    state_t          state, state_n;
    logic [N-1:0]    sreg, sreg_n;
    logic [BW-1:0]   bcnt, bcnt_n;
    logic [7:0]      pcnt, pcnt_n;
    logic            sout_q, sout_n;
`ifdef SREG_TX_PARITY_EN
    logic            par, par_n;
`endif

    // Next-state, datapath and next serial-output decode.
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        bcnt_n  = bcnt;
        pcnt_n  = pcnt;
`ifdef SREG_TX_PARITY_EN
        par_n   = par;
`endif
        sout_n  = 1'b1;

        case (state)
            IDLE: begin
                // A handshake takes priority over abort, which is meaningless here.
                if (start_valid) begin
                    sreg_n  = din;
                    bcnt_n  = '0;
                    pcnt_n  = '0;
`ifdef SREG_TX_PARITY_EN
                    par_n   = ^din;
`endif
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (pcnt == PER_LAST) begin
                    pcnt_n = '0;
                    sreg_n = sreg >> 1;
                    if (bcnt == BIT_LAST) begin
`ifdef SREG_TX_PARITY_EN
                        state_n = PAR;
`else
                        state_n = DONE;
`endif
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end else begin
                    pcnt_n = pcnt + 8'd1;
                end
            end
`ifdef SREG_TX_PARITY_EN
            PAR: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (pcnt == PER_LAST) begin
                    pcnt_n  = '0;
                    state_n = DONE;
                end else begin
                    pcnt_n = pcnt + 8'd1;
                end
            end
`endif
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // sout is registered, so it is computed from where the FSM is heading.
        case (state_n)
            SHIFT:   sout_n = sreg_n[0];
`ifdef SREG_TX_PARITY_EN
            PAR:     sout_n = par_n;
`endif
            default: sout_n = 1'b1;
        endcase
    end

    // State and datapath registers; reset drives the line idle without a clock.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sreg   <= '0;
            bcnt   <= '0;
            pcnt   <= '0;
            sout_q <= 1'b1;
`ifdef SREG_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            sreg   <= sreg_n;
            bcnt   <= bcnt_n;
            pcnt   <= pcnt_n;
            sout_q <= sout_n;
`ifdef SREG_TX_PARITY_EN
            par    <= par_n;
`endif
        end
    end

    assign sout        = sout_q;
    assign start_ready = (state == IDLE);
    assign done        = (state == DONE);
`ifdef SREG_TX_PARITY_EN
    assign busy        = (state == SHIFT) || (state == PAR);
`else
    assign busy        = (state == SHIFT);
`endif

endmodule
